ht_phase_sequencer: RTL and testbench

- Controller that sequences one hash-table instance through per-partition phases: clear/re-init, build, drain, probe, flush.
- Runs once per partition for a programmed number of partitions, then signals done.
- Sits between the partition fetch streams (build side and probe side) and the hash table.
- Generates probe serial numbers and collects per-partition and total statistics.

---
 rtl/ht_phase_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ht_phase_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_phase_sequencer.sv
// Sequences one hash-table instance through clear/init/build/drain/probe/flush per partition.
// Latency: stream-to-table valid/ready/data paths are combinational; phase control is registered.
// Backpressure: table readies pass straight back to the active stream; the inactive stream sees ready=0.
module ht_phase_sequencer #(
  parameter int NUM_ROWS     = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int PART_BITS    = 8,
  parameter int CNT_BITS     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [PART_BITS-1:0] num_partitions,
  input  logic                 s_build_valid,
  output logic                 s_build_ready,
  input  logic                 s_build_last,
  input  logic [63:0]          s_build_data,
  input  logic [31:0]          s_build_hash,
  input  logic                 s_probe_valid,
  output logic                 s_probe_ready,
  input  logic                 s_probe_last,
  input  logic [63:0]          s_probe_data,
  input  logic [31:0]          s_probe_hash,
  output logic                 ht_resetn,
  output logic                 ht_in_valid_build,
  input  logic                 ht_in_ready_build,
  output logic                 ht_last_build,
  output logic                 ht_in_valid_probe,
  input  logic                 ht_in_ready_probe,
  output logic                 ht_last_probe,
  output logic [63:0]          ht_data,
  output logic [31:0]          ht_hash,
  output logic [63:0]          ht_serialnum,
  input  logic                 ht_out_valid,
  input  logic                 ht_out_last,
  input  logic                 ht_out_was_joined,
  input  logic                 out_ready,
  output logic [PART_BITS-1:0] part_idx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_BITS-1:0]  build_cnt,
  output logic [CNT_BITS-1:0]  probe_cnt,
  output logic [CNT_BITS-1:0]  match_cnt,
  output logic [CNT_BITS-1:0]  total_match
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_BUILD, S_DRAIN, S_PROBE, S_FLUSH, S_DONE
  } state_t;

  // Terminal values of the shared phase counter; INIT waits NUM_ROWS+1 cycles.
  localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] INIT_LAST  = 16'(NUM_ROWS);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
  localparam logic [PART_BITS-1:0] PART_ONE = PART_BITS'(1);

  state_t               state;
  logic [15:0]          phase_cnt;
  logic [PART_BITS-1:0] num_parts;
  logic [63:0]          serial;

  logic in_build;
  logic in_probe;
  logic build_fire;
  logic probe_fire;
  logic res_seen;
  logic match_hit;
  logic last_part;

  assign in_build = (state == S_BUILD);
  assign in_probe = (state == S_PROBE);

  // Zero-latency forwarding, gated so each stream only reaches the table in its own phase.
  assign ht_in_valid_build = in_build & s_build_valid;
  assign s_build_ready     = in_build & ht_in_ready_build;
  assign ht_last_build     = in_build & s_build_last;
  assign ht_in_valid_probe = in_probe & s_probe_valid;
  assign s_probe_ready     = in_probe & ht_in_ready_probe;
  assign ht_last_probe     = in_probe & s_probe_last;
  assign ht_data           = in_probe ? s_probe_data : s_build_data;
  assign ht_hash           = in_probe ? s_probe_hash : s_build_hash;
  assign ht_serialnum      = serial;

  assign build_fire = in_build & s_build_valid & ht_in_ready_build;
  assign probe_fire = in_probe & s_probe_valid & ht_in_ready_probe;
  assign res_seen   = ht_out_valid & out_ready;
  assign match_hit  = (in_probe | (state == S_FLUSH)) & res_seen & ht_out_was_joined;
  assign last_part  = (part_idx == (num_parts - PART_ONE));

  // Phase FSM with registered status, table reset and statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      num_parts   <= '0;
      serial      <= '0;
      ht_resetn   <= 1'b0;
      part_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      build_cnt   <= '0;
      probe_cnt   <= '0;
      match_cnt   <= '0;
      total_match <= '0;
    end else begin
      // Result matches only occur in PROBE/FLUSH, so they never collide with the clears below.
      if (match_hit) begin
        match_cnt   <= match_cnt + CNT_ONE;
        total_match <= total_match + CNT_ONE;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_parts   <= num_partitions;
            total_match <= '0;
            part_idx    <= '0;
            phase_cnt   <= '0;
            if (num_partitions == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_CLEAR;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          ht_resetn <= 1'b0;
          build_cnt <= '0;
          probe_cnt <= '0;
          match_cnt <= '0;
          serial    <= '0;
          if (phase_cnt == CLEAR_LAST) begin
            state     <= S_INIT;
            ht_resetn <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_INIT: begin
          if (phase_cnt == INIT_LAST) begin
            state     <= S_BUILD;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_BUILD: begin
          if (build_fire) begin
            build_cnt <= build_cnt + CNT_ONE;
            if (s_build_last) begin
              state     <= S_DRAIN;
              phase_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (phase_cnt == DRAIN_LAST) begin
            state     <= S_PROBE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end
        S_PROBE: begin
          if (probe_fire) begin
            serial    <= serial + 64'd1;
            probe_cnt <= probe_cnt + CNT_ONE;
            if (s_probe_last) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (res_seen && ht_out_last) begin
            ht_resetn <= 1'b0;
            phase_cnt <= '0;
            if (last_part) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_CLEAR;
              part_idx <= part_idx + PART_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ht_phase_sequencer.sv
// Directed bench for ht_phase_sequencer: phase timing, forwarding, statistics, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
// Table-side accepts are captured by a posedge monitor and compared against hand-computed lists.
module tb_ht_phase_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  num_partitions;
  logic        s_build_valid, s_build_ready, s_build_last;
  logic [63:0] s_build_data;
  logic [31:0] s_build_hash;
  logic        s_probe_valid, s_probe_ready, s_probe_last;
  logic [63:0] s_probe_data;
  logic [31:0] s_probe_hash;
  logic        ht_resetn;
  logic        ht_in_valid_build, ht_in_ready_build, ht_last_build;
  logic        ht_in_valid_probe, ht_in_ready_probe, ht_last_probe;
  logic [63:0] ht_data;
  logic [31:0] ht_hash;
  logic [63:0] ht_serialnum;
  logic        ht_out_valid, ht_out_last, ht_out_was_joined, out_ready;
  logic [7:0]  part_idx;
  logic        busy, done;
  logic [31:0] build_cnt, probe_cnt, match_cnt, total_match;

  int checks = 0;
  int failures = 0;
  int to_cnt = 0;

  logic [63:0] build_q[$];
  logic [31:0] hash_q[$];
  logic [63:0] serial_q[$];
  int          rise_cnt = 0;
  int          lastb_cnt = 0;
  int          lastp_cnt = 0;
  logic        prev_htr = 1'b0;

  always #5 clk = ~clk;

  ht_phase_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .num_partitions(num_partitions),
    .s_build_valid(s_build_valid), .s_build_ready(s_build_ready), .s_build_last(s_build_last),
    .s_build_data(s_build_data), .s_build_hash(s_build_hash),
    .s_probe_valid(s_probe_valid), .s_probe_ready(s_probe_ready), .s_probe_last(s_probe_last),
    .s_probe_data(s_probe_data), .s_probe_hash(s_probe_hash),
    .ht_resetn(ht_resetn),
    .ht_in_valid_build(ht_in_valid_build), .ht_in_ready_build(ht_in_ready_build),
    .ht_last_build(ht_last_build),
    .ht_in_valid_probe(ht_in_valid_probe), .ht_in_ready_probe(ht_in_ready_probe),
    .ht_last_probe(ht_last_probe),
    .ht_data(ht_data), .ht_hash(ht_hash), .ht_serialnum(ht_serialnum),
    .ht_out_valid(ht_out_valid), .ht_out_last(ht_out_last),
    .ht_out_was_joined(ht_out_was_joined), .out_ready(out_ready),
    .part_idx(part_idx), .busy(busy), .done(done),
    .build_cnt(build_cnt), .probe_cnt(probe_cnt), .match_cnt(match_cnt),
    .total_match(total_match)
  );

  // Table-side observer: what the hash table actually receives.
  always @(posedge clk) begin
    if (ht_in_valid_build && ht_in_ready_build) begin
      build_q.push_back(ht_data);
      hash_q.push_back(ht_hash);
      if (ht_last_build) lastb_cnt++;
    end
    if (ht_in_valid_probe && ht_in_ready_probe) begin
      serial_q.push_back(ht_serialnum);
      if (ht_last_probe) lastp_cnt++;
    end
    if (ht_resetn && !prev_htr) rise_cnt++;
    prev_htr = ht_resetn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    num_partitions = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_build(input logic [63:0] d, input logic [31:0] h, input logic l, output int waits);
    s_build_valid = 1'b1; s_build_data = d; s_build_hash = h; s_build_last = l;
    waits = 0;
    #1;
    while (!s_build_ready && waits < 200) begin
      @(posedge clk); #2; waits++;
    end
    if (!s_build_ready) begin to_cnt++; waits = -1; end
    @(posedge clk); #1;
    s_build_valid = 1'b0; s_build_last = 1'b0;
  endtask

  task automatic send_probe(input logic [63:0] d, input logic l, output int waits);
    s_probe_valid = 1'b1; s_probe_data = d; s_probe_hash = d[31:0]; s_probe_last = l;
    waits = 0;
    #1;
    while (!s_probe_ready && waits < 200) begin
      @(posedge clk); #2; waits++;
    end
    if (!s_probe_ready) begin to_cnt++; waits = -1; end
    @(posedge clk); #1;
    s_probe_valid = 1'b0; s_probe_last = 1'b0;
  endtask

  task automatic send_result(input logic j, input logic l);
    ht_out_valid = 1'b1; ht_out_was_joined = j; ht_out_last = l; out_ready = 1'b1;
    tick();
    ht_out_valid = 1'b0; ht_out_was_joined = 1'b0; ht_out_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    if (!done) to_cnt++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; num_partitions = 8'd0;
    s_build_valid = 1'b1; s_build_last = 1'b0; s_build_data = 64'h0; s_build_hash = 32'h0;
    s_probe_valid = 1'b1; s_probe_last = 1'b0; s_probe_data = 64'h0; s_probe_hash = 32'h0;
    ht_in_ready_build = 1'b1; ht_in_ready_probe = 1'b1;
    ht_out_valid = 1'b0; ht_out_last = 1'b0; ht_out_was_joined = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, ht_resetn, s_build_ready, s_probe_ready, ht_in_valid_build, ht_in_valid_probe} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy, done, ht_resetn, s_build_ready, s_probe_ready, ht_in_valid_build, ht_in_valid_probe});
    end
    checks++;
    if (build_cnt !== 0 || probe_cnt !== 0 || match_cnt !== 0 || total_match !== 0) begin
      failures++;
      $display("FAIL reset_cnts: got %0d/%0d/%0d/%0d expected 0/0/0/0", build_cnt, probe_cnt, match_cnt, total_match);
    end
    checks++;
    if (part_idx !== 8'd0 || ht_serialnum !== 64'd0) begin
      failures++;
      $display("FAIL reset_idx_serial: got %0d/%0d expected 0/0", part_idx, ht_serialnum);
    end
    s_build_valid = 1'b0; s_probe_valid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int w, low, init, n, base, sbase, lb, lp;
    base = build_q.size(); sbase = serial_q.size(); lb = lastb_cnt; lp = lastp_cnt;
    s_probe_valid = 1'b1; s_probe_data = 64'hBAD;
    pulse_start(8'd1);
    low = 0; init = 0; n = 0;
    while (!s_build_ready && n < 60) begin
      if (!ht_resetn) low++; else init++;
      tick(); n++;
    end
    checks++;
    if (low !== 2 || init !== 9) begin
      failures++;
      $display("FAIL single_clear_init: got low=%0d init=%0d expected low=2 init=9", low, init);
    end
    send_build(64'h11, 32'hA1, 1'b0, w);
    checks++;
    if (s_probe_ready !== 1'b0 || ht_in_valid_probe !== 1'b0) begin
      failures++;
      $display("FAIL probe_in_build: got ready=%b valid=%b expected 0/0", s_probe_ready, ht_in_valid_probe);
    end
    send_build(64'h22, 32'hA2, 1'b0, w);
    send_build(64'h33, 32'hA3, 1'b1, w);
    send_probe(64'h1001, 1'b0, w);
    checks++;
    if (w !== 4) begin
      failures++;
      $display("FAIL drain_gap: got %0d cycles expected 4", w);
    end
    send_probe(64'h1002, 1'b1, w);
    send_result(1'b1, 1'b0);
    send_result(1'b0, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got done=%b busy=%b expected 1/0", done, busy);
    end
    checks++;
    if (build_cnt !== 3 || probe_cnt !== 2 || match_cnt !== 1 || total_match !== 1) begin
      failures++;
      $display("FAIL single_cnts: got %0d/%0d/%0d/%0d expected 3/2/1/1", build_cnt, probe_cnt, match_cnt, total_match);
    end
    checks++;
    if (serial_q.size() != sbase + 2 || serial_q[sbase] !== 64'd0 || serial_q[sbase+1] !== 64'd1) begin
      failures++;
      $display("FAIL single_serials: got %0d entries expected serials 0,1", serial_q.size() - sbase);
    end
    checks++;
    if (build_q.size() != base + 3 || build_q[base] !== 64'h11 || build_q[base+1] !== 64'h22 ||
        build_q[base+2] !== 64'h33 || hash_q[base+2] !== 32'hA3) begin
      failures++;
      $display("FAIL single_build_data: got %0d beats expected 11,22,33 hash A3", build_q.size() - base);
    end
    checks++;
    if (lastb_cnt - lb !== 1 || lastp_cnt - lp !== 1) begin
      failures++;
      $display("FAIL single_lasts: got %0d/%0d expected 1/1", lastb_cnt - lb, lastp_cnt - lp);
    end
  endtask

  task automatic test_flush_hold();
    int w;
    pulse_start(8'd1);
    send_build(64'h44, 32'hB4, 1'b1, w);
    send_probe(64'h2001, 1'b1, w);
    ht_out_valid = 1'b1; ht_out_was_joined = 1'b1; ht_out_last = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || match_cnt !== 0) begin
      failures++;
      $display("FAIL flush_hold: got busy=%b done=%b match=%0d expected 1/0/0", busy, done, match_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 1) begin
      failures++;
      $display("FAIL flush_release: got done=%b busy=%b match=%0d expected 1/0/1", done, busy, match_cnt);
    end
    checks++;
    if (build_cnt !== 1 || probe_cnt !== 1) begin
      failures++;
      $display("FAIL flush_dummy_cnts: got %0d/%0d expected 1/1", build_cnt, probe_cnt);
    end
    ht_out_valid = 1'b0; ht_out_was_joined = 1'b0; ht_out_last = 1'b0;
  endtask

  task automatic test_backpressure();
    int k, base, acc, w;
    logic [63:0] exp_d [4];
    exp_d[0] = 64'hD0; exp_d[1] = 64'hD1; exp_d[2] = 64'hD2; exp_d[3] = 64'hD3;
    base = build_q.size(); k = 0; acc = 0;
    pulse_start(8'd1);
    for (int cyc = 0; cyc < 200 && k < 4; cyc++) begin
      ht_in_ready_build = cyc[0];
      s_build_valid = 1'b1; s_build_data = exp_d[k]; s_build_hash = 32'(k); s_build_last = (k == 3);
      #1;
      if (s_build_ready && ht_in_valid_build) begin k++; acc++; end
      tick();
    end
    s_build_valid = 1'b0; s_build_last = 1'b0; ht_in_ready_build = 1'b1;
    checks++;
    if (acc !== 4 || build_q.size() != base + 4) begin
      failures++;
      $display("FAIL bp_accepts: got %0d/%0d expected 4/4", acc, build_q.size() - base);
    end
    checks++;
    if (build_q[base] !== 64'hD0 || build_q[base+1] !== 64'hD1 || build_q[base+2] !== 64'hD2 || build_q[base+3] !== 64'hD3) begin
      failures++;
      $display("FAIL bp_order: got %h %h %h %h expected d0 d1 d2 d3", build_q[base], build_q[base+1], build_q[base+2], build_q[base+3]);
    end
    send_probe(64'h3001, 1'b1, w);
    send_result(1'b0, 1'b1);
    wait_done();
    checks++;
    if (build_cnt !== 4 || match_cnt !== 0) begin
      failures++;
      $display("FAIL bp_cnts: got build=%0d match=%0d expected 4/0", build_cnt, match_cnt);
    end
  endtask

  task automatic test_multi();
    int w, rbase;
    rbase = rise_cnt;
    pulse_start(8'd3);
    for (int p = 0; p < 3; p++) begin
      send_build(64'(p * 16), 32'(p), 1'b0, w);
      if (p == 0) begin start = 1'b1; num_partitions = 8'd1; end
      send_build(64'(p * 16 + 1), 32'(p), 1'b1, w);
      start = 1'b0;
      checks++;
      if (part_idx !== 8'(p)) begin
        failures++;
        $display("FAIL multi_part_idx: got %0d expected %0d", part_idx, p);
      end
      send_probe(64'(p), 1'b0, w);
      send_probe(64'(p + 8), 1'b1, w);
      send_result(1'b1, 1'b0);
      send_result(1'b1, 1'b1);
    end
    checks++;
    if (done !== 1'b1 || part_idx !== 8'd2) begin
      failures++;
      $display("FAIL multi_done: got done=%b part=%0d expected 1/2", done, part_idx);
    end
    checks++;
    if (total_match !== 6 || match_cnt !== 2) begin
      failures++;
      $display("FAIL multi_matches: got total=%0d part=%0d expected 6/2", total_match, match_cnt);
    end
    checks++;
    if (rise_cnt - rbase !== 3) begin
      failures++;
      $display("FAIL multi_ht_reset_pulses: got %0d expected 3", rise_cnt - rbase);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    pulse_start(8'd2);
    send_build(64'h55, 32'hC5, 1'b1, w);
    send_probe(64'h4001, 1'b0, w);
    checks++;
    if (probe_cnt !== 1 || ht_serialnum !== 64'd1) begin
      failures++;
      $display("FAIL mid_probe_state: got cnt=%0d serial=%0d expected 1/1", probe_cnt, ht_serialnum);
    end
    s_probe_valid = 1'b1; ht_in_ready_probe = 1'b1;
    resetn = 1'b0;
    tick();
    checks++;
    if ({busy, done, ht_resetn, s_probe_ready, ht_in_valid_probe} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_ctrl: got %b expected 00000", {busy, done, ht_resetn, s_probe_ready, ht_in_valid_probe});
    end
    checks++;
    if (probe_cnt !== 0 || build_cnt !== 0 || ht_serialnum !== 64'd0 || part_idx !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_cnts: got %0d/%0d/%0d/%0d expected 0/0/0/0", probe_cnt, build_cnt, ht_serialnum, part_idx);
    end
    resetn = 1'b1; s_probe_valid = 1'b0;
    tick();
    pulse_start(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_parts: got done=%b busy=%b expected 1/0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flush_hold();
    test_backpressure();
    test_multi();
    test_reset_mid();
    checks++;
    if (to_cnt !== 0) begin
      failures++;
      $display("FAIL handshake_timeouts: got %0d expected 0", to_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
